imem_boot_arbiter: RTL and testbench

Controller that owns the single-port 4096×32 instruction memory and shares it between the MIPS core's fetch port and a boot loader stream. After reset it holds the core stalled, streams a program image into memory word by word, then releases the core and serves fetches with fixed one-cycle read latency. It sits between the `mips` core, the `iram_4096_32` instance and the program-load source in the top level.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_boot_arbiter.sv | 105 ++++++++++
 tb/tb_imem_boot_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction-memory boot arbiter.
package imem_pkg;

  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 4096;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_boot_arbiter.sv
// Boots the instruction RAM from a loader stream, then serves core fetches (1-cycle read latency).
// Optional IMEM_PATCH_EN: loader keeps write access in RUN and wins over fetches, stalling the core.
module imem_boot_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              boot_done,
  output logic [ADDR_W:0]   ld_count
);

`ifdef IMEM_PATCH_EN
  localparam bit PATCH_EN = 1'b1;
`else
  localparam bit PATCH_EN = 1'b0;
`endif

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              boot_done_q, boot_done_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] instr_hold_q, instr_hold_d;

  logic              wr_grant;
  logic              fetch_grant;
  logic [ADDR_W-1:0] fetch_word;
  logic              unused_fetch_bits;

  assign fetch_word        = fetch_addr[ADDR_W+1:2];
  assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  // Reset suppresses both grants so no write or read is issued while it is held.
  assign ld_ready    = (state_q == IMEM_LOAD) || PATCH_EN;
  assign wr_grant    = ld_valid && ld_ready && !rst;
  assign fetch_grant = (state_q == IMEM_RUN) && fetch_req && !wr_grant && !rst;

  assign mem_wren    = wr_grant;
  assign mem_address = wr_grant ? wr_ptr_q : fetch_word;
  assign mem_data    = ld_data;

  assign cpu_stall   = (state_q == IMEM_LOAD) || wr_grant;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_valid_q ? mem_q : instr_hold_q;
  assign boot_done   = boot_done_q;
  assign ld_count    = ld_count_q;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    ld_count_d    = ld_count_q;
    boot_done_d   = boot_done_q;
    fetch_valid_d = fetch_grant;
    instr_hold_d  = fetch_valid_q ? mem_q : instr_hold_q;

    if (wr_grant) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      ld_count_d = ld_count_q + 1'b1;
      if (state_q == IMEM_LOAD) begin
        // The last addressable word closes the image even without ld_last.
        if (ld_last || (&wr_ptr_q)) begin
          state_d     = IMEM_RUN;
          boot_done_d = 1'b1;
        end
      end else if (ld_last) begin
        wr_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IMEM_LOAD;
      wr_ptr_q      <= '0;
      ld_count_q    <= '0;
      boot_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      instr_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      ld_count_q    <= ld_count_d;
      boot_done_q   <= boot_done_d;
      fetch_valid_q <= fetch_valid_d;
      instr_hold_q  <= instr_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a behavioural 4096x32 synchronous RAM.
module tb_imem_boot_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              cpu_stall;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              boot_done;
  logic [ADDR_W:0]   ld_count;

  logic [DATA_W-1:0] ram [4096];

  int checks = 0;
  int errors = 0;

  imem_boot_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .cpu_stall(cpu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .boot_done(boot_done), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [3];
  int bad_addr;

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    mem_q = '0;
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();

    // Reset state; a handshake under reset must not write.
    ld_valid = 1'b1; ld_data = 32'hBAD0_BAD0;
    #1;
    chk("rst_boot_done", boot_done, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_instr", fetch_instr, 0);
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_mem_wren", mem_wren, 0);
    tick();
    chk("rst_count_after_hs", ld_count, 0);

    // Three-word boot image.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_data = prog[k]; ld_last = (k == 2);
      #1;
      chk("load_wren", mem_wren, 1);
      chk("load_addr", mem_address, k);
      chk("load_stall", cpu_stall, 1);
      chk("load_boot_done_low", boot_done, 0);
      tick();
      chk("load_count", ld_count, k + 1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    chk("boot_done", boot_done, 1);
    chk("run_stall", cpu_stall, 0);
`ifdef IMEM_PATCH_EN
    chk("run_ld_ready", ld_ready, 1);
`else
    chk("run_ld_ready", ld_ready, 0);
`endif
    chk("ram0", ram[0], 32'h2008_0005);
    chk("ram1", ram[1], 32'h2009_0007);
    chk("ram2", ram[2], 32'h0109_5020);

    // Back-to-back fetches; upper PC bits ignored on the third.
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    chk("fetch0_addr", mem_address, 0);
    chk("fetch0_wren", mem_wren, 0);
    tick();
    fetch_addr = 32'h4;
    chk("fetch0_valid", fetch_valid, 1);
    chk("fetch0_instr", fetch_instr, 32'h2008_0005);
    tick();
    fetch_addr = 32'hFFFF_C008;
    #1;
    chk("fetch2_addr", mem_address, 2);
    chk("fetch1_valid", fetch_valid, 1);
    chk("fetch1_instr", fetch_instr, 32'h2009_0007);
    tick();
    fetch_req = 1'b0;
    chk("fetch2_valid", fetch_valid, 1);
    chk("fetch2_instr", fetch_instr, 32'h0109_5020);
    tick();
    chk("fetch_idle_valid", fetch_valid, 0);
    chk("fetch_hold_instr", fetch_instr, 32'h0109_5020);

`ifdef IMEM_PATCH_EN
    // Patch collides with a fetch of the same word; the write wins.
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'hC;
    #1;
    chk("patch_wren", mem_wren, 1);
    chk("patch_addr", mem_address, 3);
    chk("patch_stall", cpu_stall, 1);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("patch_no_valid", fetch_valid, 0);
    chk("patch_count", ld_count, 4);
    #1;
    chk("patch_retry_stall", cpu_stall, 0);
    tick();
    chk("patch_retry_valid", fetch_valid, 1);
    chk("patch_retry_instr", fetch_instr, 32'hDEAD_BEEF);
    fetch_req = 1'b0; ld_valid = 1'b1; ld_data = 32'h2008_0005;
    #1;
    chk("patch_ptr_wrap", mem_address, 0);
    tick();
    ld_valid = 1'b0;
`else
    // Loader is ignored in RUN; fetch still granted.
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    #1;
    chk("run_ld_ignored", mem_wren, 0);
    chk("run_ld_stall", cpu_stall, 0);
    chk("run_ld_addr", mem_address, 1);
    tick();
    ld_valid = 1'b0; fetch_req = 1'b0;
    chk("run_ld_fetch_valid", fetch_valid, 1);
    chk("run_ld_fetch_instr", fetch_instr, 32'h2009_0007);
    chk("run_ld_count", ld_count, 3);
    tick();
`endif

    // Fetches during LOAD are ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ldfetch_stall", cpu_stall, 1);
      tick();
      chk("ldfetch_no_valid", fetch_valid, 0);
    end
    fetch_req = 1'b0;

    // Reset mid-load (2 of 5 words), then reload from address 0.
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1; ld_data = 32'h1111_0000 + k;
      tick();
    end
    chk("midload_count", ld_count, 2);
    rst = 1'b1; ld_data = 32'h3333_3333;
    #1;
    chk("midload_rst_wren", mem_wren, 0);
    tick();
    rst = 1'b0; ld_data = 32'hAAAA_0000;
    chk("midload_rst_count", ld_count, 0);
    chk("midload_rst_boot", boot_done, 0);
    chk("midload_ram2_kept", ram[2], 32'h0109_5020);
    #1;
    chk("reload_addr", mem_address, 0);
    tick();
    ld_valid = 1'b0;
    chk("reload_ram0", ram[0], 32'hAAAA_0000);
    chk("reload_count", ld_count, 1);

    // Full 4096-word image with no ld_last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad_addr = 0;
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1; ld_data = 32'h5A5A_0000 ^ i; ld_last = 1'b0;
      #1;
      if (mem_address != i[ADDR_W-1:0] || !mem_wren) bad_addr++;
      if (i == 4095) chk("full_boot_before_last", boot_done, 0);
      tick();
    end
    chk("full_addr_seq", bad_addr, 0);
    chk("full_count", ld_count, 4096);
    chk("full_boot_done", boot_done, 1);
    chk("full_stall", cpu_stall, 0);
    chk("full_ram_last", ram[4095], 32'h5A5A_0FFF);
    chk("full_ram_first", ram[0], 32'h5A5A_0000);
    ld_data = 32'h7777_7777;
    #1;
`ifdef IMEM_PATCH_EN
    chk("full_patch_wrap_addr", mem_address, 0);
`else
    chk("full_no_more_writes", mem_wren, 0);
`endif
    tick();
    ld_valid = 1'b0;
`ifndef IMEM_PATCH_EN
    chk("full_count_stable", ld_count, 4096);
`endif
    fetch_req = 1'b1; fetch_addr = 32'h3FFC;
    tick();
    fetch_req = 1'b0;
    chk("full_fetch_valid", fetch_valid, 1);
    chk("full_fetch_instr", fetch_instr, 32'h5A5A_0FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
